// File: rtl/spi_dispatch_pkg.sv
// spi_dispatch_pkg: opcodes, status codes, FSM states and field positions for the SPI command dispatcher
package spi_dispatch_pkg;
  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_DAC_WR  = 4'h1;
  localparam logic [3:0] OP_ADC_WR  = 4'h2;
  localparam logic [3:0] OP_ADC_RD  = 4'h3;
  localparam logic [3:0] OP_ECHO    = 4'hF;
  localparam logic [3:0] ST_OK      = 4'd0;
  localparam logic [3:0] ST_BAD_OP  = 4'd1;
  localparam logic [3:0] ST_TIMEOUT = 4'd2;
  localparam int CMD_OP_LSB       = 28;
  localparam int CMD_DAC_ADDR_LSB = 24;
  localparam int CMD_ADC_ADDR_LSB = 8;
  localparam int CMD_VALUE_LSB    = 0;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_RISE, S_WAIT_FALL, S_RESPOND
  } state_t;
  function automatic logic is_spi_op(input logic [3:0] op);
    return op == OP_DAC_WR || op == OP_ADC_WR || op == OP_ADC_RD;
  endfunction
  function automatic logic [31:0] make_resp(input logic [3:0] op, input logic [3:0] st,
                                            input logic [15:0] hi, input logic [7:0] lo);
    return {op, st, hi, lo};
  endfunction
endpackage

// File: rtl/spi_command_dispatcher.sv
// spi_command_dispatcher: pops host command words, drives one SPI request each, writes a response word (optional busy timeout via SPI_DISPATCH_TIMEOUT_EN)
module spi_command_dispatcher
  import spi_dispatch_pkg::*;
#(
  parameter int BUSY_RISE_WAIT = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] cmd_q,
  input  logic        cmd_empty,
  output logic        cmd_rdreq,
  output logic [31:0] rb_data,
  input  logic        rb_full,
  output logic        rb_wrreq,
  output logic        data_ready,
  output logic        dac_request_write,
  output logic [3:0]  dac_address,
  output logic [15:0] dac_value,
  output logic        adc_request_write,
  output logic        adc_request_read,
  output logic [15:0] adc_address,
  output logic [7:0]  adc_value,
  input  logic [7:0]  adc_value_readback,
  input  logic        busy,
  output logic        idle,
  output logic [7:0]  err_count
);
  state_t      r_state;
  logic [3:0]  r_op, r_status;
  logic [15:0] r_hi;
  logic [7:0]  r_lo, r_rise_cnt, r_err;
  logic        r_cmd_rdreq, r_rb_wrreq, r_data_ready, r_dac_wr, r_adc_wr, r_adc_rd;
  logic [31:0] r_rb_data;
  logic [3:0]  r_dac_addr;
  logic [15:0] r_dac_val, r_adc_addr;
  logic [7:0]  r_adc_val;
  logic [3:0]  w_op;
`ifdef SPI_DISPATCH_TIMEOUT_EN
  logic [15:0] r_to;
`endif
  assign w_op              = cmd_q[CMD_OP_LSB +: 4];
  assign idle              = r_state == S_IDLE && cmd_empty;
  assign cmd_rdreq         = r_cmd_rdreq;
  assign rb_data           = r_rb_data;
  assign rb_wrreq          = r_rb_wrreq;
  assign data_ready        = r_data_ready;
  assign dac_request_write = r_dac_wr;
  assign dac_address       = r_dac_addr;
  assign dac_value         = r_dac_val;
  assign adc_request_write = r_adc_wr;
  assign adc_request_read  = r_adc_rd;
  assign adc_address       = r_adc_addr;
  assign adc_value         = r_adc_val;
  assign err_count         = r_err;
  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_status     <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_rise_cnt   <= '0;
      r_err        <= '0;
      r_cmd_rdreq  <= 1'b0;
      r_rb_wrreq   <= 1'b0;
      r_data_ready <= 1'b0;
      r_dac_wr     <= 1'b0;
      r_adc_wr     <= 1'b0;
      r_adc_rd     <= 1'b0;
      r_rb_data    <= '0;
      r_dac_addr   <= '0;
      r_dac_val    <= '0;
      r_adc_addr   <= '0;
      r_adc_val    <= '0;
`ifdef SPI_DISPATCH_TIMEOUT_EN
      r_to         <= '0;
`endif
    end else begin
      r_cmd_rdreq  <= 1'b0;
      r_rb_wrreq   <= 1'b0;
      r_data_ready <= 1'b0;
      r_dac_wr     <= 1'b0;
      r_adc_wr     <= 1'b0;
      r_adc_rd     <= 1'b0;
      case (r_state)
        S_IDLE: if (!cmd_empty && !r_rb_wrreq) begin
          r_cmd_rdreq <= 1'b1;
          r_state     <= S_FETCH;
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: if (!busy) begin
          r_op     <= w_op;
          r_hi     <= cmd_q[CMD_ADC_ADDR_LSB +: 16];
          r_lo     <= cmd_q[CMD_VALUE_LSB +: 8];
          r_status <= (is_spi_op(w_op) || w_op == OP_ECHO) ? ST_OK : ST_BAD_OP;
          if (w_op == OP_DAC_WR) begin
            r_dac_addr <= cmd_q[CMD_DAC_ADDR_LSB +: 4];
            r_dac_val  <= cmd_q[CMD_VALUE_LSB +: 16];
          end
          if (w_op == OP_ADC_WR || w_op == OP_ADC_RD) r_adc_addr <= cmd_q[CMD_ADC_ADDR_LSB +: 16];
          if (w_op == OP_ADC_WR) r_adc_val <= cmd_q[CMD_VALUE_LSB +: 8];
          r_state <= w_op == OP_NOP ? S_IDLE : is_spi_op(w_op) ? S_ISSUE : S_RESPOND;
        end
        S_ISSUE: begin
          r_dac_wr   <= r_op == OP_DAC_WR;
          r_adc_wr   <= r_op == OP_ADC_WR;
          r_adc_rd   <= r_op == OP_ADC_RD;
          r_rise_cnt <= '0;
`ifdef SPI_DISPATCH_TIMEOUT_EN
          r_to       <= '0;
`endif
          r_state    <= S_WAIT_RISE;
        end
        S_WAIT_RISE:
          if (busy) r_state <= S_WAIT_FALL;
          else if (r_rise_cnt == 8'(BUSY_RISE_WAIT - 1)) r_state <= S_RESPOND;
          else r_rise_cnt <= r_rise_cnt + 8'd1;
        S_WAIT_FALL:
          if (!busy) begin
            if (r_op == OP_ADC_RD) r_lo <= adc_value_readback;
            r_state <= S_RESPOND;
          end
`ifdef SPI_DISPATCH_TIMEOUT_EN
          else if (r_to == 16'(TIMEOUT_CYCLES - 1)) begin
            r_status <= ST_TIMEOUT;
            if (r_op == OP_ADC_RD) r_lo <= 8'h00;
            r_state  <= S_RESPOND;
          end else r_to <= r_to + 16'd1;
`endif
        S_RESPOND: if (!rb_full) begin
          r_rb_wrreq   <= 1'b1;
          r_data_ready <= 1'b1;
          r_rb_data    <= make_resp(r_op, r_status, r_hi, r_lo);
          if (r_status != ST_OK && r_err != 8'hFF) r_err <= r_err + 8'd1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: doc/spi_command_dispatcher.md
Name: spi_command_dispatcher

Overview:
- Sits in the sys_clk domain between the command FIFO read port and the SPI controller, plus the readback FIFO write port.
- Pops 32-bit host command words, decodes each into a DAC write, ADC write, ADC read or echo, and issues one spi_controller request per word.
- Waits for the SPI transaction to finish, then pushes one 32-bit response word into the readback FIFO and pulses data_ready for the host trigger-out.

Parameters:
- BUSY_RISE_WAIT, 4: cycles after a request to wait for busy to rise; if busy never rises, the transaction counts as complete.
- TIMEOUT_CYCLES, 65535: maximum cycles busy may stay high (used only with the optional feature).

Ports:
- sys_clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- cmd_q  in  32  command FIFO q (normal mode, valid 1 cycle after rdreq)
- cmd_empty  in  1  command FIFO rdempty
- cmd_rdreq  out  1  command FIFO read request
- rb_data  out  32  readback FIFO data
- rb_full  in  1  readback FIFO full
- rb_wrreq  out  1  readback FIFO write request
- data_ready  out  1  one-cycle pulse per response written
- dac_request_write  out  1  one-cycle DAC write strobe
- dac_address  out  4  DAC channel/chip address
- dac_value  out  16  DAC code
- adc_request_write  out  1  one-cycle ADC register write strobe
- adc_request_read  out  1  one-cycle ADC register read strobe
- adc_address  out  16  {chip[2:0], reg[12:0]}
- adc_value  out  8  ADC register write data
- adc_value_readback  in  8  ADC read result, valid when busy falls
- busy  in  1  SPI controller busy
- idle  out  1  high in IDLE with cmd_empty high
- err_count  out  8  saturating count of error responses

Behaviour:
- Reset: all strobes, cmd_rdreq, rb_wrreq and data_ready are 0; all address/value/rb_data registers and err_count are 0; idle is 1; state is IDLE. Reset mid-transaction abandons the command with no response; a half-popped word is lost.
- Command word fields: opcode [31:28].
  - 0x0 NOP: consumed, no response.
  - 0x1 DAC_WRITE: dac_address = [27:24], dac_value = [15:0].
  - 0x2 ADC_WRITE: adc_address = [23:8], adc_value = [7:0].
  - 0x3 ADC_READ: adc_address = [23:8].
  - 0xF ECHO: no SPI access.
  - Any other opcode is an error.
- Response word: {opcode[3:0], status[3:0], payload[23:0]}.
  - status: 0 = OK, 1 = BAD_OPCODE, 2 = TIMEOUT.
  - payload: for ADC_READ, {cmd[23:8], adc_value_readback}; otherwise cmd[23:0] unchanged.
- State machine:
  - IDLE: if !cmd_empty, assert cmd_rdreq for 1 cycle and go to FETCH.
  - FETCH: 1 wait cycle, then go to DECODE.
  - DECODE: latch cmd_q and set address/value outputs. NOP goes to IDLE. ECHO and bad opcode go to RESPOND. Otherwise go to ISSUE.
  - ISSUE: assert exactly one request strobe for 1 cycle; go to WAIT_RISE.
  - WAIT_RISE: when busy goes high, go to WAIT_FALL. After BUSY_RISE_WAIT cycles without busy, go to RESPOND.
  - WAIT_FALL: when busy goes low, capture adc_value_readback on that cycle and go to RESPOND.
  - RESPOND: while rb_full, hold with no write. Otherwise drive rb_wrreq and data_ready for 1 cycle with rb_data valid, then go to IDLE.
- Throughput: no request is issued while busy is high. If busy is already high in DECODE, wait in DECODE until it goes low before ISSUE. Minimum 5 cycles per ECHO.
- Address/value outputs hold their last values between commands; only the strobes return to 0.
- err_count increments on every response with status != 0 and saturates at 255.

Optional Feature:
- Macro: SPI_DISPATCH_TIMEOUT_EN.
- When defined: a 16-bit counter runs in WAIT_FALL. If it reaches TIMEOUT_CYCLES, go to RESPOND with status 2 (payload readback byte 0x00), increment err_count, then continue normally.
- When undefined: WAIT_FALL waits indefinitely and status 2 is never produced.

Decomposition:
- Shared package spi_dispatch_pkg holds:
  - opcode constants OP_NOP, OP_DAC_WR, OP_ADC_WR, OP_ADC_RD, OP_ECHO;
  - status constants ST_OK, ST_BAD_OP, ST_TIMEOUT;
  - state encoding;
  - command and response field bit positions.
- No sub-module: the FSM, field latches and counters fit in one module.

Test Plan:
- Push 0xF0ABCDEF -> one response 0xF0ABCDEF, one data_ready pulse, no SPI strobe; err_count stays 0.
- Push 0x13001234, model busy high 3..20 cycles after strobe -> dac_request_write high 1 cycle with dac_address=3, dac_value=0x1234; response 0x10001234 only after busy falls.
- Push 0x3_0_00A5_00 (ADC_READ chip 0 reg 0x0A5), model returns 0x5C -> adc_address=0x00A5, adc_request_read pulses once, response 0x3000A55C.
- Push 0x70000001 -> response 0x71000001, err_count=1, no SPI activity; push 0x00000000 (NOP) -> no response.
- Hold rb_full high for 50 cycles during ECHO -> no rb_wrreq until rb_full falls, then exactly one write; cmd_rdreq not asserted meanwhile.
- With SPI_DISPATCH_TIMEOUT_EN defined and TIMEOUT_CYCLES=100, keep busy stuck high -> response 0x32<addr>00 after 100 cycles and err_count increments; assert reset mid-WAIT_FALL -> all outputs 0, idle=1, no response.
